// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - time-multiplexed 7-segment scan controller with frame-boundary data swap
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int DRIVE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  output logic                    load_ready,
  output logic [3:0]              dec_nibble,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAX_CYC = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [0:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_active_data;
  logic [NUM_DIGITS-1:0]   r_active_blank;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_valid;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_done;

  logic                    w_xfer;
  logic                    w_frame_end;
  logic                    w_apply;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_cur_blank;
  logic                    w_lit;
  logic [4*NUM_DIGITS-1:0] w_data_shift;

  assign load_ready   = ~r_pend_valid;
  assign w_xfer       = load_valid & ~r_pend_valid;
  assign w_frame_end  = enable & (r_state == S_DRIVE) & (r_idx == IDX_LAST) & (r_cnt == DRIVE_LAST);
  // While disabled there is no frame to protect, so a pending update lands at once.
  assign w_apply      = r_pend_valid & (w_frame_end | ~enable);
  assign w_onehot     = NUM_DIGITS'(1) << r_idx;
  assign w_cur_blank  = |(r_active_blank & w_onehot);
  assign w_lit        = enable & (r_state == S_DRIVE) & ~w_cur_blank;
  assign w_data_shift = r_active_data >> {r_idx, 2'b00};
  assign dec_nibble   = w_data_shift[3:0];

  assign seg        = r_seg;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;

  // Host handshake into pending buffer and pending-to-active swap at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_data    <= '0;
      r_pend_blank   <= '0;
      r_pend_valid   <= 1'b0;
      r_active_data  <= '0;
      r_active_blank <= '0;
    end else begin
      if (w_xfer) begin
        r_pend_data  <= load_data;
        r_pend_blank <= load_blank;
        r_pend_valid <= 1'b1;
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
      end
      if (w_apply) begin
        r_active_data  <= r_pend_data;
        r_active_blank <= r_pend_blank;
      end
    end
  end

  // Blank/drive slot sequencer walking the digit index.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state <= S_BLANK;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_BLANK) begin
      if (r_cnt == BLANK_LAST) begin
        r_state <= S_DRIVE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      if (r_cnt == DRIVE_LAST) begin
        r_state <= S_BLANK;
        r_cnt   <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Registered display pins, one cycle behind the sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= '0;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_lit ? dec_seg : 7'd0;
      r_digit_en   <= w_lit ? w_onehot : '0;
      r_frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller (4/2/4 and 1/1/1 instances)
module tb_seg_scan_controller;

  typedef struct packed {
    logic        fd;
    logic [15:0] den;
    logic [6:0]  seg;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable;

  logic        lv0, rdy0, fd0;
  logic [15:0] ld0;
  logic [3:0]  lb0, nib0, den0;
  logic [6:0]  dseg0, seg0;

  logic        lv1, rdy1, fd1;
  logic [3:0]  ld1, nib1;
  logic [0:0]  lb1, den1;
  logic [6:0]  dseg1, seg1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int          nd [2] = '{4, 1};
  int          bc [2] = '{2, 1};
  int          dc [2] = '{4, 1};
  int          tt [2];
  logic [63:0] act_data [2];
  logic [63:0] pnd_data [2];
  logic [15:0] act_blank [2];
  logic [15:0] pnd_blank [2];
  bit          pnd_v [2];

  function automatic logic [6:0] lut(input logic [3:0] n);
    case (n)
      4'h0: lut = 7'h3F; 4'h1: lut = 7'h06; 4'h2: lut = 7'h5B; 4'h3: lut = 7'h4F;
      4'h4: lut = 7'h66; 4'h5: lut = 7'h6D; 4'h6: lut = 7'h7D; 4'h7: lut = 7'h07;
      4'h8: lut = 7'h7F; 4'h9: lut = 7'h6F; 4'hA: lut = 7'h77; 4'hB: lut = 7'h7C;
      4'hC: lut = 7'h39; 4'hD: lut = 7'h5E; 4'hE: lut = 7'h79; default: lut = 7'h71;
    endcase
  endfunction

  assign dseg0 = lut(nib0);
  assign dseg1 = lut(nib1);

  seg_scan_controller #(.NUM_DIGITS(4), .BLANK_CYCLES(2), .DRIVE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .load_valid(lv0), .load_data(ld0),
    .load_blank(lb0), .load_ready(rdy0), .dec_nibble(nib0), .dec_seg(dseg0),
    .seg(seg0), .digit_en(den0), .frame_done(fd0));

  seg_scan_controller #(.NUM_DIGITS(1), .BLANK_CYCLES(1), .DRIVE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .load_valid(lv1), .load_data(ld1),
    .load_blank(lb1), .load_ready(rdy1), .dec_nibble(nib1), .dec_seg(dseg1),
    .seg(seg1), .digit_en(den1), .frame_done(fd1));

  // Reference: position in frame t; slot = t / slot_len, lit in the last DRIVE part of a slot.
  function automatic exp_t model_step(input int k, input bit r, input bit en, input bit lv,
                                      input logic [63:0] ld, input logic [15:0] lb);
    exp_t e;
    int   slen, flen, slot, w;
    bit   fe;
    e    = '0;
    slen = bc[k] + dc[k];
    flen = nd[k] * slen;
    if (r) begin
      tt[k] = 0; act_data[k] = '0; pnd_data[k] = '0;
      act_blank[k] = '0; pnd_blank[k] = '0; pnd_v[k] = 1'b0;
      e.rdy = 1'b1;
      return e;
    end
    if (en) begin
      slot = tt[k] / slen;
      w    = tt[k] % slen;
      if (w >= bc[k] && !act_blank[k][slot]) begin
        e.seg = lut(act_data[k][4*slot +: 4]);
        e.den = 16'd1 << slot;
      end
      e.fd = (tt[k] == flen - 1);
    end
    fe = en && (tt[k] == flen - 1);
    if (pnd_v[k] && (fe || !en)) begin
      act_data[k]  = pnd_data[k];
      act_blank[k] = pnd_blank[k];
      pnd_v[k]     = 1'b0;
    end else if (lv && !pnd_v[k]) begin
      pnd_data[k]  = ld;
      pnd_blank[k] = lb;
      pnd_v[k]     = 1'b1;
    end
    tt[k] = en ? (tt[k] + 1) % flen : 0;
    e.rdy = !pnd_v[k];
    return e;
  endfunction

  // Expected pin values for the cycle after each edge are queued at that edge.
  always @(posedge clk) begin
    q0.push_back(model_step(0, rst, enable, lv0, 64'(ld0), 16'(lb0)));
    q1.push_back(model_step(1, rst, enable, lv1, 64'(ld1), 16'(lb1)));
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
    end
  endtask

  // Monitor: compares every presented output cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("seg0", 32'(seg0), 32'(e.seg));
      check("digit_en0", 32'(den0), 32'(e.den[3:0]));
      check("frame_done0", 32'(fd0), 32'(e.fd));
      check("load_ready0", 32'(rdy0), 32'(e.rdy));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("seg1", 32'(seg1), 32'(e.seg));
      check("digit_en1", 32'(den1), 32'(e.den[0:0]));
      check("frame_done1", 32'(fd1), 32'(e.fd));
      check("load_ready1", 32'(rdy1), 32'(e.rdy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load0(input logic [15:0] d, input logic [3:0] b);
    lv0 = 1'b1; ld0 = d; lb0 = b;
    cyc(1);
    lv0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1;
    lv0 = 1'b0; ld0 = '0; lb0 = '0;
    lv1 = 1'b0; ld1 = '0; lb1 = '0;
    cyc(3);
    rst = 1'b0;
    // first frame with 1238, blank none
    lv1 = 1'b1; ld1 = 4'h8;
    load0(16'h1238, 4'h0);
    lv1 = 1'b0;
    cyc(60);
    // frame-boundary swap: A mid-frame, then B held valid
    cyc(10);
    load0(16'hA5C3, 4'h0);
    lv0 = 1'b1; ld0 = 16'h7E91; lb0 = 4'h0;
    cyc(30);
    lv0 = 1'b0;
    cyc(60);
    // blank mask on digit 2
    load0(16'h4F2D, 4'b0100);
    cyc(60);
    // restart frame, then drop enable mid-DRIVE of digit 1 with a load while disabled
    rst = 1'b1; cyc(1); rst = 1'b0;
    load0(16'h9876, 4'h0);
    cyc(8);
    enable = 1'b0;
    load0(16'h0BEF, 4'h0);
    cyc(5);
    enable = 1'b1;
    cyc(40);
    // reset with an update still pending
    load0(16'h5555, 4'h0);
    load0(16'h6666, 4'h0);
    rst = 1'b1; cyc(2); rst = 1'b0;
    cyc(50);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      lv0    = ($urandom_range(0, 5) == 0);
      ld0    = 16'($urandom);
      lb0    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lv1    = ($urandom_range(0, 3) == 0);
      ld1    = 4'($urandom);
      lb1    = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
      enable = ($urandom_range(0, 60) != 0);
      rst    = ($urandom_range(0, 400) == 0);
      cyc(1);
    end
    rst = 1'b0; enable = 1'b1; lv0 = 1'b0; lv1 = 1'b0;
    cyc(3);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
